flt16_to_int16: RTL and testbench

//  Downstream stage of float16 component extraction. Takes extracted sign, biased exponent and
//  11-bit significand (hidden bit restored) and produces a saturated two's-complement int16.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/int_sat_neg.sv | 27 ++
 rtl/flt16_to_int16.sv | 122 ++++++++++++
 tb/tb_flt16_to_int16.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared float16 field definitions and the float-to-int converter state encoding.
package fp_pkg;

    localparam int unsigned EXP_W     = 5;
    localparam int unsigned MAN_W     = 11;
    localparam int unsigned INT_W     = 16;
    localparam int unsigned BIAS      = 15;
    localparam int unsigned MAX_RSH   = 11;
    localparam int unsigned EXP_SAT   = 30;
    // Exponent at which the 11-bit significand is already an integer (no shift needed).
    localparam int unsigned EXP_UNITY = BIAS + 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        FIX,
        DONE
    } f2i_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp16_fields_t;

endpackage

// File: rtl/int_sat_neg.sv
// Applies sign and saturation to the shifted magnitude, producing the final int16 result.
module int_sat_neg
    import fp_pkg::*;
(
    input  logic             sign_i,
    input  logic             sat_i,
    input  logic [INT_W-2:0] acc_i,
    output logic [INT_W-1:0] int_o,
    output logic             sat_o
);

    logic [INT_W-1:0] mag;

    always_comb begin
        mag   = {1'b0, acc_i};
        sat_o = sat_i;
        if (sat_i) begin
            int_o = sign_i ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
        end else if (sign_i) begin
            // Negating a zero magnitude yields zero, so -0 needs no special case.
            int_o = -mag;
        end else begin
            int_o = mag;
        end
    end

endmodule

// File: rtl/flt16_to_int16.sv
// Iterative float16-to-int16 converter: one shift per cycle, truncating toward zero, saturating.
module flt16_to_int16
    import fp_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sign,
    input  logic [EXP_W-1:0] Exp,
    input  logic [MAN_W-1:0] Mant,
    output logic [INT_W-1:0] IntOut,
    output logic             Sat,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned AccW = INT_W - 1;
    localparam int unsigned CntW = 4;

    f2i_state_t       state_q;
    fp16_fields_t     fields_q;
    logic [AccW-1:0]  acc_q;
    logic [CntW-1:0]  cnt_q;
    logic             dir_left_q;
    logic             sat_flag_q;
    logic [INT_W-1:0] int_out_q;
    logic             sat_q;
    logic             busy_q;
    logic             done_q;

    logic [AccW-1:0]  load_acc;
    logic [CntW-1:0]  load_cnt;
    logic             load_left;
    logic             load_sat;
    logic [EXP_W-1:0] rsh;
    logic [INT_W-1:0] fix_int;
    logic             fix_sat;

    // Shift setup derived from the captured operand; consumed in LOAD.
    always_comb begin
        load_acc  = {{(AccW-MAN_W){1'b0}}, fields_q.mant};
        load_cnt  = '0;
        load_left = 1'b0;
        load_sat  = 1'b0;
        rsh       = EXP_W'(EXP_UNITY) - fields_q.exp;
        if (fields_q.exp == '0) begin
            load_acc = '0;
        end else if (fields_q.exp >= EXP_W'(EXP_SAT)) begin
            load_sat = 1'b1;
        end else if (fields_q.exp >= EXP_W'(EXP_UNITY)) begin
            load_left = 1'b1;
            load_cnt  = CntW'(fields_q.exp - EXP_W'(EXP_UNITY));
        end else if (rsh > EXP_W'(MAX_RSH)) begin
            load_cnt = CntW'(MAX_RSH);
        end else begin
            load_cnt = CntW'(rsh);
        end
    end

    int_sat_neg u_int_sat_neg (
        .sign_i (fields_q.sign),
        .sat_i  (sat_flag_q),
        .acc_i  (acc_q),
        .int_o  (fix_int),
        .sat_o  (fix_sat)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            fields_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            dir_left_q <= 1'b0;
            sat_flag_q <= 1'b0;
            int_out_q  <= '0;
            sat_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        fields_q <= '{sign: Sign, exp: Exp, mant: Mant};
                        state_q  <= LOAD;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                LOAD: begin
                    acc_q      <= load_acc;
                    cnt_q      <= load_cnt;
                    dir_left_q <= load_left;
                    sat_flag_q <= load_sat;
                    state_q    <= (load_cnt == '0) ? FIX : SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == '0) begin
                        state_q <= FIX;
                    end else begin
                        acc_q <= dir_left_q ? (acc_q << 1) : (acc_q >> 1);
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    int_out_q <= fix_int;
                    sat_q     <= fix_sat;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IntOut = int_out_q;
    assign Sat    = sat_q;
    assign Busy   = busy_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_flt16_to_int16.sv
// Directed-vector bench for flt16_to_int16 with hand-computed results and a behavioural model.
module tb_flt16_to_int16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign_in;
    logic [4:0]  exp_in;
    logic [10:0] mant_in;
    logic [15:0] int_out;
    logic        sat;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        s;
        logic [4:0]  e;
        logic [10:0] m;
        logic [15:0] v;
        logic        sat;
    } vec_t;

    vec_t vecs [15];

    flt16_to_int16 dut (
        .Clk    (clk),
        .Reset  (rst_n),
        .Start  (start),
        .Sign   (sign_in),
        .Exp    (exp_in),
        .Mant   (mant_in),
        .IntOut (int_out),
        .Sat    (sat),
        .Busy   (busy),
        .Done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // trunc(mant/1024 * 2^(exp-15)) with clamp; bit 16 is the saturation flag.
    function automatic logic [16:0] model(input logic s, input logic [4:0] e,
                                          input logic [10:0] m);
        int          mag;
        logic [15:0] v;
        if (e == 5'd0) return 17'd0;
        if (e >= 5'd30) return {1'b1, (s ? 16'h8000 : 16'h7FFF)};
        if (e >= 5'd25) mag = int'(m) << (int'(e) - 25);
        else mag = int'(m) >> (25 - int'(e));
        v = s ? 16'(-mag) : 16'(mag);
        return {1'b0, v};
    endfunction

    // Returns edges from the accepting edge until Done is seen high (capped at 40).
    task automatic run_op(input logic s, input logic [4:0] e, input logic [10:0] m,
                          output int lat);
        @(negedge clk);
        sign_in = s;
        exp_in  = e;
        mant_in = m;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        check("busy_after_accept", 32'(busy), 32'd1);
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        int          lat;
        int          cnt;
        logic [16:0] mdl;

        vecs = '{
            '{1'b0, 5'd15, 11'h400, 16'h0001, 1'b0},
            '{1'b0, 5'd18, 11'h700, 16'h000E, 1'b0},
            '{1'b1, 5'd16, 11'h600, 16'hFFFD, 1'b0},
            '{1'b0, 5'd14, 11'h7FF, 16'h0000, 1'b0},
            '{1'b1, 5'd29, 11'h780, 16'h8800, 1'b0},
            '{1'b0, 5'd30, 11'h400, 16'h7FFF, 1'b1},
            '{1'b1, 5'd30, 11'h5A5, 16'h8000, 1'b1},
            '{1'b0, 5'd31, 11'h000, 16'h7FFF, 1'b1},
            '{1'b1, 5'd0,  11'h000, 16'h0000, 1'b0},
            '{1'b0, 5'd0,  11'h000, 16'h0000, 1'b0},
            '{1'b0, 5'd0,  11'h3FF, 16'h0000, 1'b0},
            '{1'b0, 5'd5,  11'h7FF, 16'h0000, 1'b0},
            '{1'b0, 5'd25, 11'h400, 16'h0400, 1'b0},
            '{1'b1, 5'd29, 11'h7FF, 16'h8010, 1'b0},
            '{1'b0, 5'd24, 11'h7FF, 16'h03FF, 1'b0}
        };

        rst_n   = 1'b0;
        start   = 1'b0;
        sign_in = 1'b0;
        exp_in  = '0;
        mant_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_intout", 32'(int_out), 32'd0);
        check("reset_sat", 32'(sat), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].s, vecs[i].e, vecs[i].m, lat);
            mdl = model(vecs[i].s, vecs[i].e, vecs[i].m);
            check($sformatf("v%0d_intout", i), 32'(int_out), 32'(vecs[i].v));
            check($sformatf("v%0d_sat", i), 32'(sat), 32'(vecs[i].sat));
            check($sformatf("v%0d_model", i), {15'd0, sat, int_out}, 32'(mdl));
            check($sformatf("v%0d_busy_done", i), 32'(busy), 32'd0);
            if (vecs[i].e != 5'd0 && vecs[i].e < 5'd30 && vecs[i].e != 5'd25) begin
                cnt = (vecs[i].e > 5'd25) ? int'(vecs[i].e) - 25 : 25 - int'(vecs[i].e);
                if (cnt > 11) cnt = 11;
                check($sformatf("v%0d_latency", i), 32'(lat), 32'(3 + cnt));
            end
        end

        // Done and the result are held while Start stays low.
        repeat (3) @(posedge clk);
        #1;
        check("done_held", 32'(done), 32'd1);
        check("result_held", 32'(int_out), 32'h03FF);

        // A Start pulse mid-SHIFT with different operands must be ignored.
        @(negedge clk);
        sign_in = 1'b0;
        exp_in  = 5'd15;
        mant_in = 11'h400;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("done_drops_on_accept", 32'(done), 32'd0);
        lat = 0;
        repeat (3) begin
            @(posedge clk);
            #1 lat++;
        end
        @(negedge clk);
        sign_in = 1'b1;
        exp_in  = 5'd29;
        mant_in = 11'h780;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat++;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check("ignore_start_done", 32'(done), 32'd1);
        check("ignore_start_intout", 32'(int_out), 32'h0001);
        check("ignore_start_latency", 32'(lat), 32'd13);

        // Reset asserted mid-SHIFT clears everything on the next edge.
        @(negedge clk);
        sign_in = 1'b0;
        exp_in  = 5'd14;
        mant_in = 11'h7FF;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_intout", 32'(int_out), 32'd0);
        check("midreset_sat", 32'(sat), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 5'd16, 11'h600, lat);
        check("post_reset_intout", 32'(int_out), 32'hFFFD);
        check("post_reset_latency", 32'(lat), 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
